fp_addsub_pipe: RTL and testbench
=================================

// Module: fp_addsub_pipe
// PURPOSE
//  3-stage pipelined FP32 adder/subtractor that consumes the products of the butterfly multiplier
//  stage and forms the butterfly sums/differences (e.g. Xr = Ar*Wr - Ai*Wi).
//  Numerics match the multiplier: truncation only, no NaN/Inf/denormal support, zero = exponent 0.
//  valid/ready handshake on both sides; an opaque tag rides along for butterfly bookkeeping.
// PARAMETERS
//  TAG_W    4  width of the pass-through tag (butterfly/lane index)
//  OVF_SAT  1  1: exponent overflow -> signed max finite (0x7F7FFFFF); 0: exponent wraps mod 256
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block accepts the pair this cycle
//  a          in   32     FP32 operand A
//  b          in   32     FP32 operand B
//  sub        in   1      1: result = A - B; 0: result = A + B
//  in_tag     in   TAG_W  tag captured with the operands
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  result     out  32     FP32 result
//  out_tag    out  TAG_W  tag associated with result
// BEHAVIOUR
//  - Reset: all stage valid bits=0; out_valid=0, result=0, out_tag=0. Reset mid-operation drops
//    in-flight data without producing output. Data registers are not required to be reset.
//  - Handshake: adv = !out_valid | out_ready; in_ready = adv. All stages shift together when adv=1.
//    Transfer on in_valid&in_ready; result consumed on out_valid&out_ready. result/out_tag hold
//    stable while out_valid & !out_ready. Throughput is 1/clk; latency is 3 clk from accept to out_valid.
//  - Zero rule: operand is zero iff exp==0 (mantissa ignored, -0 is zero).
//    Effective Bs = b[31]^sub. A zero -> result={Bs,b[30:0]}; B zero -> a; both zero -> 32'h0.
//  - S1 align: compare {exp,man} magnitudes; larger -> L, smaller -> S (on a tie, A is L).
//    d = expL-expS; mS = {1,manS}>>d (24 bit, bits shifted out are truncated, d>=24 -> 0).
//    op = signL ^ signS (1 = magnitude subtract).
//  - S2 add: m = op ? {1'b0,mL}-{1'b0,mS} : {1'b0,mL}+{1'b0,mS} (25 bit, never negative).
//    The sign of the result is signL.
//  - S3 normalize/pack: m[24]=1 -> man=m[23:1], exp=expL+1. Otherwise lz=lzc(m[23:0]),
//    man=(m<<lz)[22:0], exp=expL-lz.
//    m==0 (exact cancel) -> 32'h0 (+0).
//    Exponent computed in 10-bit signed; <=0 -> 32'h0 (flush). >=255 -> OVF_SAT?{s,0x7F7FFFFF}:low 8 bits.
//  - exp==255 inputs are treated as ordinary finite numbers.
// STRUCTURE
//  - Shared package fp32_pkg: FP32_EXP_W=8, FP32_MAN_W=23, FP32_BIAS=127, FP32_ZERO=32'h0,
//    FP32_MAX=32'h7F7FFFFF, field-extract functions.
//    The multiplier stage and the future complex-butterfly top also use this package.
//  - One sub-module: lzc24 (combinational 24-bit leading-zero count, 5-bit out, all-zero -> 24).
//  - Pipeline registers per stage: valid, sign, exp, mantissa(s), op, tag, zero-bypass flag + value.
// TESTING
//  1. a=3F800000,b=3F800000,sub=0 -> result 40000000 exactly 3 clk after accept, out_tag=in_tag.
//  2. a=40400000(3.0),b=3F800000,sub=1 -> 40000000; a=3FC00000,b=3FC00000,sub=1 -> 00000000.
//  3. a=3F800000,b=30800000(2^-30),sub=0 -> 3F800000 (truncation); a=0,b=3F800000,sub=1 -> BF800000.
//  4. Back-to-back 8 pairs with tags 0..7, out_ready low for 5 cycles mid-stream -> in_ready low
//     while stalled, result held stable, all 8 results in order and none lost or duplicated.
//  5. OVF_SAT=1: 7F7FFFFF+7F7FFFFF -> 7F7FFFFF.
//     Underflow case: 00800000 - 00C00000 -> 00000000 (flush).
//  6. Assert rst asynchronously with 3 items in flight -> out_valid=0 immediately.
//     After release, a new pair yields only its own result.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 field definitions and helpers for the butterfly datapath.
// This FP32 format has no NaN, Inf or denormals. A value is zero exactly when its exponent is 0.
package fp32_pkg;

  localparam int unsigned FP32_EXP_W = 8;
  localparam int unsigned FP32_MAN_W = 23;
  localparam int unsigned FP32_BIAS  = 127;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_MAX  = 32'h7F7F_FFFF;

  function automatic logic fp32_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [FP32_EXP_W-1:0] fp32_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [FP32_MAN_W-1:0] fp32_man(input logic [31:0] x);
    return x[22:0];
  endfunction

  // The mantissa is ignored, so -0 and any exp==0 pattern count as zero.
  function automatic logic fp32_is_zero(input logic [31:0] x);
    return (x[30:23] == '0);
  endfunction

endpackage

// File: rtl/lzc24.sv
// Combinational 24-bit leading-zero counter. An all-zero input returns 24.
module lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // Scan upward so that the most significant set bit is the one that sets the count.
  always_comb begin
    count = 5'd24;
    for (int unsigned i = 0; i < 24; i++) begin
      if (value[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// 3-stage truncating FP32 adder/subtractor for the butterfly datapath.
// The stages are S1 align, S2 add and S3 normalize/pack. All stages advance together.
module fp_addsub_pipe
  import fp32_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter bit          OVF_SAT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] out_tag
);

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1: zero bypass, operand swap, alignment ----------------
  logic [31:0] b_eff, l_op, s_op, byp_val_c;
  logic        a_zero, b_zero, a_is_l;
  logic [7:0]  d;
  logic [23:0] ms_full, ms_shift;

  // Pick the larger magnitude, then right-shift the smaller one into alignment (truncating).
  always_comb begin
    b_eff     = {b[31] ^ sub, b[30:0]};
    a_zero    = fp32_is_zero(a);
    b_zero    = fp32_is_zero(b);
    a_is_l    = (a[30:0] >= b[30:0]);
    l_op      = a_is_l ? a : b_eff;
    s_op      = a_is_l ? b_eff : a;
    d         = fp32_exp(l_op) - fp32_exp(s_op);
    ms_full   = {1'b1, fp32_man(s_op)};
    ms_shift  = (d >= 8'd24) ? 24'd0 : (ms_full >> d);
    byp_val_c = (a_zero && b_zero) ? FP32_ZERO : (a_zero ? b_eff : a);
  end

  logic             s1_valid, s1_sign, s1_op, s1_byp;
  logic [7:0]       s1_exp;
  logic [23:0]      s1_ml, s1_ms;
  logic [31:0]      s1_byp_val;
  logic [TAG_W-1:0] s1_tag;

  // S1 valid bit. It is cleared by reset so that in-flight data is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      s1_valid <= 1'b0;
    else if (adv) s1_valid <= in_valid;
  end

  // S1 data registers. These are not reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign    <= fp32_sign(l_op);
      s1_op      <= fp32_sign(l_op) ^ fp32_sign(s_op);
      s1_exp     <= fp32_exp(l_op);
      s1_ml      <= {1'b1, fp32_man(l_op)};
      s1_ms      <= ms_shift;
      s1_byp     <= a_zero | b_zero;
      s1_byp_val <= byp_val_c;
      s1_tag     <= in_tag;
    end
  end

  // ---------------- S2: magnitude add/subtract ----------------
  logic             s2_valid, s2_sign, s2_byp;
  logic [7:0]       s2_exp;
  logic [24:0]      s2_m;
  logic [31:0]      s2_byp_val;
  logic [TAG_W-1:0] s2_tag;

  // S2 valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      s2_valid <= 1'b0;
    else if (adv) s2_valid <= s1_valid;
  end

  // S2 data registers. L >= S in magnitude, so the difference is never negative.
  always_ff @(posedge clk) begin
    if (adv) begin
      s2_m       <= s1_op ? ({1'b0, s1_ml} - {1'b0, s1_ms}) : ({1'b0, s1_ml} + {1'b0, s1_ms});
      s2_sign    <= s1_sign;
      s2_exp     <= s1_exp;
      s2_byp     <= s1_byp;
      s2_byp_val <= s1_byp_val;
      s2_tag     <= s1_tag;
    end
  end

  // ---------------- S3: normalize and pack ----------------
  logic [4:0]        lz;
  logic [22:0]       man_lz, man_n;
  logic signed [9:0] exp_n;
  logic [31:0]       res_c;

  lzc24 u_lzc (
    .value (s2_m[23:0]),
    .count (lz)
  );

  assign man_lz = 23'(s2_m[23:0] << lz);

  // Renormalize, then flush results with exponent <= 0 and saturate or wrap those with exponent >= 255.
  always_comb begin
    if (s2_m[24]) begin
      man_n = s2_m[23:1];
      exp_n = $signed({2'b00, s2_exp}) + 10'sd1;
    end else begin
      man_n = man_lz;
      exp_n = $signed({2'b00, s2_exp}) - $signed({5'b00000, lz});
    end
    if (s2_byp)                res_c = s2_byp_val;
    else if (s2_m == '0)       res_c = FP32_ZERO;
    else if (exp_n <= 10'sd0)  res_c = FP32_ZERO;
    else if (exp_n >= 10'sd255 && OVF_SAT) res_c = {s2_sign, FP32_MAX[30:0]};
    else                       res_c = {s2_sign, exp_n[7:0], man_n};
  end

  // Output register. It holds result and tag while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= FP32_ZERO;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      result    <= res_c;
      out_tag   <= s2_tag;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed self-checking bench for fp_addsub_pipe. It covers numerics, latency, stalls and async reset.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  in_tag, out_tag;

  int n_total = 0;
  int n_pass  = 0;

  fp_addsub_pipe #(
    .TAG_W   (4),
    .OVF_SAT (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [3:0]  tag;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", nm, act, req);
  endtask

  // Send one pair into an empty pipe, then measure latency and check the result and tag.
  task automatic apply_one(input vec_t v);
    int cyc;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    sub       = v.sub;
    in_tag    = v.tag;
    @(negedge clk);
    chk({v.name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({v.name, " latency"}, 32'(cyc), 32'd3);
    chk({v.name, " result"}, result, v.exp);
    chk({v.name, " tag"}, 32'(out_tag), 32'(v.tag));
    @(posedge clk); #1;
  endtask

  logic [31:0] st_a[8];
  logic [31:0] st_exp[8];

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 4'd5,  32'h40000000, "one_plus_one"};
    vecs[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 4'd1,  32'h40000000, "three_minus_one"};
    vecs[2]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 4'd2,  32'h00000000, "exact_cancel"};
    vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b0, 4'd3,  32'h3F800000, "tiny_truncated"};
    vecs[4]  = '{32'h00000000, 32'h3F800000, 1'b1, 4'd4,  32'hBF800000, "a_zero_sub"};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd6,  32'h7F7FFFFF, "overflow_sat"};
    vecs[6]  = '{32'h00800000, 32'h00C00000, 1'b1, 4'd7,  32'h00000000, "underflow_flush"};
    vecs[7]  = '{32'h00000000, 32'h80000000, 1'b0, 4'd8,  32'h00000000, "both_zero"};
    vecs[8]  = '{32'h40400000, 32'h00123456, 1'b0, 4'd9,  32'h40400000, "b_zero_dirty_man"};
    vecs[9]  = '{32'h3F800000, 32'hBF800000, 1'b0, 4'd10, 32'h00000000, "opp_sign_cancel"};
    vecs[10] = '{32'h40000000, 32'h40400000, 1'b1, 4'd11, 32'hBF800000, "two_minus_three"};
    vecs[11] = '{32'h41000000, 32'h3F800000, 1'b0, 4'd12, 32'h41100000, "eight_plus_one"};

    st_a   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    st_exp = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; in_tag = '0;
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset out_tag", 32'(out_tag), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) apply_one(vecs[i]);

    // Stream 8 pairs back to back while the consumer stalls for 5 cycles.
    begin
      int sent = 0, got = 0, c = 0, extra = 0;
      logic        held = 1'b0;
      logic [31:0] prev_res = '0;
      logic [3:0]  prev_tag = '0;
      while (got < 8 && c < 80) begin
        @(posedge clk); #1;
        out_ready = !(c >= 4 && c < 9);
        in_valid  = (sent < 8);
        a         = (sent < 8) ? st_a[sent] : 32'h0;
        b         = 32'h3F800000;
        sub       = 1'b0;
        in_tag    = 4'(sent);
        @(negedge clk);
        if (out_valid && !out_ready) begin
          chk("stall in_ready", 32'(in_ready), 32'd0);
          if (held) begin
            chk("stall result held", result, prev_res);
            chk("stall tag held", 32'(out_tag), 32'(prev_tag));
          end
          held = 1'b1; prev_res = result; prev_tag = out_tag;
        end else begin
          held = 1'b0;
        end
        if (out_valid && out_ready) begin
          chk("stream result", result, st_exp[got]);
          chk("stream tag", 32'(out_tag), 32'(got));
          got++;
        end
        if (in_valid && in_ready) sent++;
        c++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream all received", 32'(got), 32'd8);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (out_valid) extra++;
      end
      chk("stream no duplicates", 32'(extra), 32'd0);
    end

    // Put three items in flight against a stalled consumer, then reset asynchronously.
    begin
      int extra = 0;
      vec_t v;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1; a = 32'h40000000; b = 32'h3F800000; sub = 1'b0; in_tag = 4'(k + 1);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("pre-reset out_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async reset out_valid", 32'(out_valid), 32'd0);
      chk("async reset result", result, 32'h0);
      @(negedge clk); rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (out_valid) extra++;
      end
      chk("post-reset no stale output", 32'(extra), 32'd0);
      v = vecs[1];
      v.tag = 4'd14;
      v.name = "post_reset_pair";
      apply_one(v);
      extra = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (out_valid) extra++;
      end
      chk("post-reset single result", 32'(extra), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
